// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared constants, the per-FU result entry type and the round-robin index
//   helper used by the writeback arbiter and its per-FU result FIFOs.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int FU_NUM    = 4;                  // functional-unit result sources
    localparam int PHYS_REGS = 64;                 // physical register count
    localparam int PHYS_W    = $clog2(PHYS_REGS);  // physical tag width
    localparam int DW        = 32;                 // data width
    localparam int EPOCH_W   = 2;                  // epoch tag width
    localparam int DEPTH     = 4;                  // per-FU FIFO entries (power of 2, >= 2)

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FU_W  = $clog2(FU_NUM);

    // One queued result. valid=0 marks a stale result that is dropped silently.
    typedef struct packed {
        logic               valid;
        logic [PHYS_W-1:0]  pd;
        logic [DW-1:0]      data;
        logic [EPOCH_W-1:0] epoch;
    } wb_entry_t;

    // (base + off) mod FU_NUM, used to walk the round-robin scan order.
    function automatic logic [FU_W-1:0] rr_idx(input logic [FU_W-1:0] base, input int off);
        int sum;
        sum = 32'(base) + off;
        return FU_W'(sum % FU_NUM);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
//   Bundles the FU result inputs, the recovery (flush) event and the PRF
//   writeback handshake.
//   master : the arbiter (drives fu_ready and wb_*)
//   slave  : the environment (FUs, recovery logic, PRF write port)
// -----------------------------------------------------------------------------
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic [FU_NUM-1:0]               fu_valid;
    logic [FU_NUM-1:0]               fu_ready;
    logic [FU_NUM-1:0][PHYS_W-1:0]   fu_pd;
    logic [FU_NUM-1:0][DW-1:0]       fu_data;
    logic [FU_NUM-1:0][EPOCH_W-1:0]  fu_epoch;

    logic                            flush_valid;
    logic [EPOCH_W-1:0]              flush_epoch;

    logic                            wb_valid;
    logic                            wb_ready;
    logic [PHYS_W-1:0]               wb_pd;
    logic [DW-1:0]                   wb_data;
    logic [EPOCH_W-1:0]              wb_epoch;

    modport master (
        input  fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
        output fu_ready, wb_valid, wb_pd, wb_data, wb_epoch
    );

    modport slave (
        output fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
        input  fu_ready, wb_valid, wb_pd, wb_data, wb_epoch
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_arbiter_fifo
//   DEPTH-entry result FIFO for one functional unit, with a bulk epoch
//   invalidate used on recovery.
//   clk, rst_n      clock, synchronous active-low reset (pointers/count only)
//   push_i, entry_i write one entry (caller guarantees not full)
//   pop_i           drop the head (caller guarantees not empty)
//   flush_i         clear valid on every entry whose epoch != flush_epoch_i
//   head_o, count_o head entry (meaningful when count_o != 0), occupancy
// -----------------------------------------------------------------------------
module wb_arbiter_fifo
    import wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  wb_entry_t          entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [EPOCH_W-1:0] flush_epoch_i,
    output wb_entry_t          head_o,
    output logic [CNT_W-1:0]   count_o
);

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally modulo DEPTH.
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: the storage array is deliberately not reset; count_q gates every
    // use of it, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_i && (mem_q[i].epoch != flush_epoch_i)) mem_q[i].valid <= 1'b0;
        end
        if (push_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Collects results from FU_NUM functional units through per-FU FIFOs and
//   issues at most one PRF writeback per cycle from a registered output stage,
//   granting round-robin. Results from stale epochs are accepted but dropped.
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    wb_arbiter_if.master: fu_* inputs / fu_ready, flush_*, wb_* handshake
//   Build option: define WB_BYPASS_EN to let a result arriving at an empty
//   FIFO be granted straight into the output stage (1-cycle minimum latency).
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.master  bus
);

    wb_entry_t          in_entry [FU_NUM];
    wb_entry_t          head     [FU_NUM];
    logic [CNT_W-1:0]   count    [FU_NUM];
    logic [FU_NUM-1:0]  push, pop, fifo_ready, head_req, byp_req, cand;

    logic               load_en;
    logic               gnt_valid;
    logic [FU_W-1:0]    gnt_idx;
    logic [PHYS_W-1:0]  gnt_pd;
    logic [DW-1:0]      gnt_data;
    logic [EPOCH_W-1:0] gnt_epoch;

    logic [EPOCH_W-1:0] cur_epoch_q;
    logic [FU_W-1:0]    rr_ptr_q;
    logic               wb_valid_q;
    logic [PHYS_W-1:0]  wb_pd_q;
    logic [DW-1:0]      wb_data_q;
    logic [EPOCH_W-1:0] wb_epoch_q;

    // Request generation.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_en = (!wb_valid_q || bus.wb_ready) && !bus.flush_valid;
        for (int i = 0; i < FU_NUM; i++) begin
            // A result pushed during a flush cycle is already stale.
            in_entry[i] = '{valid: (bus.fu_epoch[i] == cur_epoch_q) && !bus.flush_valid,
                            pd:    bus.fu_pd[i],
                            data:  bus.fu_data[i],
                            epoch: bus.fu_epoch[i]};
            // Full means no push, even if the head pops this cycle.
            fifo_ready[i] = (count[i] != CNT_W'(DEPTH));
            head_req[i]   = (count[i] != '0) && head[i].valid;
`ifdef WB_BYPASS_EN
            byp_req[i]    = (count[i] == '0) && bus.fu_valid[i] && (bus.fu_epoch[i] == cur_epoch_q);
`else
            byp_req[i]    = 1'b0;
`endif
            cand[i]       = head_req[i] || byp_req[i];
        end
    end

    // Round-robin pick: scan backwards so the requester closest to rr_ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = FU_NUM - 1; k >= 0; k--) begin
            if (load_en && cand[rr_idx(rr_ptr_q, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_idx(rr_ptr_q, k);
            end
        end
    end

    // Grant source mux plus per-FIFO push/pop. byp_req implies an empty FIFO,
    // so a bypass grant never pops and its result is never enqueued.
    always_comb begin
        gnt_pd    = head[gnt_idx].pd;
        gnt_data  = head[gnt_idx].data;
        gnt_epoch = head[gnt_idx].epoch;
        if (byp_req[gnt_idx]) begin
            gnt_pd    = in_entry[gnt_idx].pd;
            gnt_data  = in_entry[gnt_idx].data;
            gnt_epoch = in_entry[gnt_idx].epoch;
        end
        for (int i = 0; i < FU_NUM; i++) begin
            pop[i]  = (count[i] != '0) &&
                      (!head[i].valid || (gnt_valid && (gnt_idx == FU_W'(i))));
            push[i] = bus.fu_valid[i] && fifo_ready[i] &&
                      !(gnt_valid && (gnt_idx == FU_W'(i)) && byp_req[i]);
        end
    end

    for (genvar g = 0; g < FU_NUM; g++) begin : g_fifo
        wb_arbiter_fifo u_fifo (
            .clk           (clk),
            .rst_n         (rst_n),
            .push_i        (push[g]),
            .entry_i       (in_entry[g]),
            .pop_i         (pop[g]),
            .flush_i       (bus.flush_valid),
            .flush_epoch_i (bus.flush_epoch),
            .head_o        (head[g]),
            .count_o       (count[g])
        );
    end

    // Output stage, current epoch and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_epoch_q <= '0;
            rr_ptr_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_pd_q     <= '0;
            wb_data_q   <= '0;
            wb_epoch_q  <= '0;
        end else if (bus.flush_valid) begin
            cur_epoch_q <= bus.flush_epoch;
            // A stale output is retracted even under backpressure; a current
            // one retires normally if accepted, otherwise keeps waiting.
            if (bus.wb_ready || (wb_epoch_q != bus.flush_epoch)) wb_valid_q <= 1'b0;
        end else if (load_en) begin
            wb_valid_q <= gnt_valid;
            if (gnt_valid) begin
                wb_pd_q    <= gnt_pd;
                wb_data_q  <= gnt_data;
                wb_epoch_q <= gnt_epoch;
                rr_ptr_q   <= rr_idx(gnt_idx, 1);
            end
        end
    end

    assign bus.fu_ready = fifo_ready;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_pd    = wb_pd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_epoch = wb_epoch_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Directed self-checking bench for wb_arbiter. Inputs change 1 ns after the
//   rising edge; outputs are read at the same point. Accepted writebacks are
//   logged on the falling edge, where wb_valid/wb_ready are stable.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [PHYS_W-1:0]  mon_pd [$];
    logic [DW-1:0]      mon_data [$];
    logic [EPOCH_W-1:0] mon_ep [$];
    int                 mon_cyc [$];

    wb_arbiter_if bus_if ();

    wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus_if.wb_valid && bus_if.wb_ready) begin
            mon_pd.push_back(bus_if.wb_pd);
            mon_data.push_back(bus_if.wb_data);
            mon_ep.push_back(bus_if.wb_epoch);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fu();
        bus_if.fu_valid    = '0;
        bus_if.fu_pd       = '0;
        bus_if.fu_data     = '0;
        bus_if.fu_epoch    = '0;
        bus_if.flush_valid = 1'b0;
        bus_if.flush_epoch = '0;
    endtask

    task automatic drive_fu(input int i, input int pd, input int data, input int ep);
        bus_if.fu_valid[i] = 1'b1;
        bus_if.fu_pd[i]    = PHYS_W'(pd);
        bus_if.fu_data[i]  = DW'(data);
        bus_if.fu_epoch[i] = EPOCH_W'(ep);
    endtask

    task automatic wait_wb(input int target, input int budget, input string name);
        int n = 0;
        while (mon_pd.size() < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (mon_pd.size() < target) begin
            errors++;
            $display("FAIL %s: got %0d writebacks, needed %0d", name, mon_pd.size(), target);
        end
    endtask

    task automatic do_reset();
        clear_fu();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_fu();
        bus_if.wb_ready = 1'b0;
        do_reset();
        checks++;
        if (bus_if.wb_valid !== 1'b0) begin
            errors++; $display("FAIL reset_wb_valid: got %b want 0", bus_if.wb_valid);
        end
        checks++;
        if ({bus_if.wb_pd, bus_if.wb_data, bus_if.wb_epoch} !== '0) begin
            errors++; $display("FAIL reset_wb_fields: pd=%0d data=%h ep=%0d want 0", bus_if.wb_pd, bus_if.wb_data, bus_if.wb_epoch);
        end
        checks++;
        if (bus_if.fu_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_fu_ready: got %b want 1111", bus_if.fu_ready);
        end
    endtask

    task automatic test_single();
        int base;
        bus_if.wb_ready = 1'b0;
        drive_fu(0, 5, 'hDEAD, 0);
        step();
        clear_fu();
        checks++;
        if (bus_if.wb_valid !== BYPASS) begin
            errors++; $display("FAIL single_latency: wb_valid=%b want %b", bus_if.wb_valid, BYPASS);
        end
        step();
        checks++;
        if ({bus_if.wb_valid, bus_if.wb_pd, bus_if.wb_data} !== {1'b1, PHYS_W'(5), DW'('hDEAD)}) begin
            errors++; $display("FAIL single_wb: valid=%b pd=%0d data=%h want 1/5/dead", bus_if.wb_valid, bus_if.wb_pd, bus_if.wb_data);
        end
        base = mon_pd.size();
        bus_if.wb_ready = 1'b1;
        step();
        checks++;
        if (bus_if.wb_valid !== 1'b0 || mon_pd.size() != base + 1) begin
            errors++; $display("FAIL single_retire: wb_valid=%b writebacks=%0d want 0/%0d", bus_if.wb_valid, mon_pd.size(), base + 1);
        end
    endtask

    // Pushes one value on every FU in the same cycle and checks the order and
    // the 1-per-cycle spacing of the resulting writebacks.
    task automatic rr_burst(input int pd0, input int first, input string name);
        int base;
        int fu;
        for (int i = 0; i < FU_NUM; i++) drive_fu(i, pd0 + i, 'h100 + pd0 + i, 0);
        base = mon_pd.size();
        step();
        clear_fu();
        wait_wb(base + FU_NUM, 20, name);
        for (int k = 0; k < FU_NUM; k++) begin
            fu = (first + k) % FU_NUM;
            checks++;
            if (base + k >= mon_pd.size() || mon_pd[base + k] !== PHYS_W'(pd0 + fu) ||
                mon_data[base + k] !== DW'('h100 + pd0 + fu) || mon_cyc[base + k] != mon_cyc[base] + k) begin
                errors++; $display("FAIL %s_slot%0d: expected FU%0d pd=%0d on consecutive cycle", name, k, fu, pd0 + fu);
            end
        end
        step();
        step();
    endtask

    task automatic test_round_robin();
        int base;
        do_reset();
        bus_if.wb_ready = 1'b1;
        rr_burst(10, 0, "rr_first");
        rr_burst(14, 0, "rr_wrapped");
        // A lone FU0 result moves the pointer to FU1 for the next burst.
        base = mon_pd.size();
        drive_fu(0, 19, 'h119, 0);
        step();
        clear_fu();
        wait_wb(base + 1, 10, "rr_single");
        step();
        rr_burst(44, 1, "rr_rotated");
    endtask

    task automatic test_back_to_back();
        int base;
        bus_if.wb_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_fu(1, 20 + k, 'h200 + k, 0);
            step();
            if (k >= 1) begin
                checks++;
                if ({bus_if.wb_valid, bus_if.wb_pd, bus_if.wb_data} !== {1'b1, PHYS_W'(20), DW'('h200)}) begin
                    errors++; $display("FAIL bp_hold_%0d: valid=%b pd=%0d data=%h want 1/20/200", k, bus_if.wb_valid, bus_if.wb_pd, bus_if.wb_data);
                end
            end
            checks++;
            if (bus_if.fu_ready[1] !== (k < 4)) begin
                errors++; $display("FAIL bp_ready_%0d: fu_ready[1]=%b want %b", k, bus_if.fu_ready[1], (k < 4));
            end
        end
        clear_fu();
        base = mon_pd.size();
        bus_if.wb_ready = 1'b1;
        wait_wb(base + 5, 20, "bp_drain");
        step(); step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (base + k >= mon_pd.size() || mon_pd[base + k] !== PHYS_W'(20 + k) ||
                mon_cyc[base + k] != mon_cyc[base] + k) begin
                errors++; $display("FAIL bp_order_%0d: expected pd=%0d on consecutive cycle", k, 20 + k);
            end
        end
        checks++;
        if (mon_pd.size() != base + 5) begin
            errors++; $display("FAIL bp_reject_full: writebacks=%0d want %0d", mon_pd.size() - base, 5);
        end
    endtask

    task automatic test_flush();
        int base;
        // Flush to the current epoch: queued and held entries survive.
        bus_if.wb_ready = 1'b0;
        drive_fu(2, 40, 'h400, 0); step();
        drive_fu(2, 41, 'h401, 0); step();
        clear_fu();
        bus_if.flush_valid = 1'b1;
        bus_if.flush_epoch = 2'd0;
        step();
        clear_fu();
        checks++;
        if ({bus_if.wb_valid, bus_if.wb_pd} !== {1'b1, PHYS_W'(40)}) begin
            errors++; $display("FAIL flush_same_hold: valid=%b pd=%0d want 1/40", bus_if.wb_valid, bus_if.wb_pd);
        end
        base = mon_pd.size();
        bus_if.wb_ready = 1'b1;
        wait_wb(base + 2, 10, "flush_same_drain");
        checks++;
        if (base + 1 >= mon_pd.size() || mon_pd[base] !== PHYS_W'(40) || mon_pd[base + 1] !== PHYS_W'(41)) begin
            errors++; $display("FAIL flush_same_order: expected pd 40 then 41");
        end
        step(); step();
        // Flush to epoch 1: held epoch-0 output and queued epoch-0 entry vanish.
        bus_if.wb_ready = 1'b0;
        drive_fu(2, 30, 'h300, 0); step();
        drive_fu(2, 31, 'h301, 0); step();
        clear_fu();
        checks++;
        if ({bus_if.wb_valid, bus_if.wb_pd} !== {1'b1, PHYS_W'(30)}) begin
            errors++; $display("FAIL flush_pre_hold: valid=%b pd=%0d want 1/30", bus_if.wb_valid, bus_if.wb_pd);
        end
        bus_if.flush_valid = 1'b1;
        bus_if.flush_epoch = 2'd1;
        step();
        clear_fu();
        checks++;
        if (bus_if.wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_retract: wb_valid=%b want 0", bus_if.wb_valid);
        end
        drive_fu(2, 32, 'h302, 1);
        step();
        clear_fu();
        base = mon_pd.size();
        bus_if.wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (mon_pd.size() != base + 1 || mon_pd[base] !== PHYS_W'(32) || mon_ep[base] !== EPOCH_W'(1)) begin
            errors++; $display("FAIL flush_survivor: writebacks=%0d want exactly pd=32 epoch=1", mon_pd.size() - base);
        end
    endtask

    task automatic test_stale();
        int base;
        bus_if.wb_ready = 1'b1;
        checks++;
        if (bus_if.fu_ready[3] !== 1'b1) begin
            errors++; $display("FAIL stale_ready: fu_ready[3]=%b want 1", bus_if.fu_ready[3]);
        end
        base = mon_pd.size();
        drive_fu(3, 50, 'h500, 0);
        step();
        clear_fu();
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (mon_pd.size() != base || bus_if.fu_ready[3] !== 1'b1) begin
            errors++; $display("FAIL stale_dropped: writebacks=%0d fu_ready[3]=%b want 0/1", mon_pd.size() - base, bus_if.fu_ready[3]);
        end
        drive_fu(3, 51, 'h501, 1);
        step();
        clear_fu();
        wait_wb(base + 1, 10, "stale_followup");
        checks++;
        if (base >= mon_pd.size() || mon_pd[base] !== PHYS_W'(51)) begin
            errors++; $display("FAIL stale_followup_pd: expected pd=51 after stale drop");
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bus_if.wb_ready = 1'b0;
        drive_fu(0, 60, 'h600, 1);
        drive_fu(1, 61, 'h601, 1);
        drive_fu(2, 62, 'h602, 1);
        step();
        clear_fu();
        step();
        checks++;
        if (bus_if.wb_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: wb_valid=%b want 1", bus_if.wb_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({bus_if.wb_valid, bus_if.wb_pd, bus_if.fu_ready} !== {1'b0, PHYS_W'(0), 4'b1111}) begin
            errors++; $display("FAIL rstmid_state: valid=%b pd=%0d fu_ready=%b want 0/0/1111", bus_if.wb_valid, bus_if.wb_pd, bus_if.fu_ready);
        end
        base = mon_pd.size();
        bus_if.wb_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (mon_pd.size() != base) begin
            errors++; $display("FAIL rstmid_nowb: writebacks=%0d want 0", mon_pd.size() - base);
        end
        // Epoch is back to 0 after reset, so an epoch-0 result is current.
        drive_fu(1, 7, 'h77, 0);
        step();
        clear_fu();
        wait_wb(base + 1, 10, "rstmid_epoch0");
        checks++;
        if (base >= mon_pd.size() || mon_pd[base] !== PHYS_W'(7) || mon_data[base] !== DW'('h77) || mon_ep[base] !== EPOCH_W'(0)) begin
            errors++; $display("FAIL rstmid_epoch0_wb: expected pd=7 data=77 epoch=0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_flush();
        test_stale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
